pwm_duty_sequencer: RTL and testbench

PWM_DUTY_SEQUENCER -- requirements
Module: pwm_duty_sequencer

---
 rtl/pwm_duty_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_pwm_duty_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_sequencer.sv
// pwm_duty_sequencer: debounced inc/dec buttons step a 0..DUTY_MAX duty value for a PWM generator.
// Optional triangle auto-ramp compiled in with macro PWM_RAMP_EN.
`default_nettype none
`timescale 1ns/1ps

module pwm_duty_sequencer #(
    parameter int DEB_CYCLES = 4,
    parameter int DUTY_MAX   = 10,
    parameter int DUTY_RST   = 5,
    parameter int RAMP_DIV   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc_btn,
    input  logic       dec_btn,
    input  logic       ramp_en,
    output logic [3:0] duty,
    output logic       duty_upd,
    output logic       ramp_dir
);

    localparam logic [7:0] c_DEB_LAST = 8'(DEB_CYCLES - 1);
    localparam logic [3:0] c_DUTY_MAX = 4'(DUTY_MAX);
    localparam logic [3:0] c_DUTY_RST = 4'(DUTY_RST);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESS   = 2'd1,
        S_HELD    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    logic       inc_meta_q, inc_sync_q, dec_meta_q, dec_sync_q;
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       press_inc_q, press_inc_d;
    logic [3:0] duty_q, duty_d;
    logic       upd_q, upd_d;
    logic       w_apply;
    logic       w_ramp_step;
    logic       w_ramp_up;

    logic w_none, w_both, w_one;
    assign w_none = ~inc_sync_q & ~dec_sync_q;
    assign w_both =  inc_sync_q &  dec_sync_q;
    assign w_one  =  inc_sync_q ^  dec_sync_q;

    // Button FSM: the step is applied exactly once, on the PRESS -> HELD transition.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        press_inc_d = press_inc_q;
        w_apply     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (w_both) begin
                    state_d = S_HELD;
                end else if (w_one) begin
                    state_d     = S_PRESS;
                    cnt_d       = 8'd0;
                    press_inc_d = inc_sync_q;
                end
            end
            S_PRESS: begin
                if (w_both) begin
                    state_d = S_HELD;
                end else if (w_one && (inc_sync_q == press_inc_q)) begin
                    if (cnt_q == c_DEB_LAST) begin
                        w_apply = 1'b1;
                        state_d = S_HELD;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HELD: begin
                if (w_none) begin
                    state_d = S_RELEASE;
                    cnt_d   = 8'd0;
                end
            end
            S_RELEASE: begin
                if (!w_none) begin
                    state_d = S_HELD;
                end else if (cnt_q == c_DEB_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        duty_d = duty_q;
        upd_d  = 1'b0;
        if (w_apply) begin
            if (press_inc_q && (duty_q != c_DUTY_MAX)) begin
                duty_d = duty_q + 4'd1;
                upd_d  = 1'b1;
            end else if (!press_inc_q && (duty_q != 4'd0)) begin
                duty_d = duty_q - 4'd1;
                upd_d  = 1'b1;
            end
        end else if (w_ramp_step) begin
            duty_d = w_ramp_up ? duty_q + 4'd1 : duty_q - 4'd1;
            upd_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inc_meta_q  <= 1'b0;
            inc_sync_q  <= 1'b0;
            dec_meta_q  <= 1'b0;
            dec_sync_q  <= 1'b0;
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            press_inc_q <= 1'b0;
            duty_q      <= c_DUTY_RST;
            upd_q       <= 1'b0;
        end else begin
            inc_meta_q  <= inc_btn;
            inc_sync_q  <= inc_meta_q;
            dec_meta_q  <= dec_btn;
            dec_sync_q  <= dec_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            press_inc_q <= press_inc_d;
            duty_q      <= duty_d;
            upd_q       <= upd_d;
        end
    end

`ifdef PWM_RAMP_EN
    localparam int         c_PW        = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;
    localparam logic [c_PW-1:0] c_PRE_LAST = c_PW'(RAMP_DIV - 1);

    logic [c_PW-1:0] presc_q, presc_d;
    logic            dir_q, dir_d;

    // If a button pushed duty onto a bound, the ramp turns around instead of stalling.
    assign w_ramp_up   = dir_q ? (duty_q != c_DUTY_MAX) : (duty_q == 4'd0);
    assign w_ramp_step = ramp_en && (state_q == S_IDLE) && (presc_q == c_PRE_LAST);

    always_comb begin
        presc_d = '0;
        dir_d   = dir_q;
        if (ramp_en && (state_q == S_IDLE) && (presc_q != c_PRE_LAST)) begin
            presc_d = presc_q + c_PW'(1);
        end
        if (w_ramp_step) begin
            if (duty_d == c_DUTY_MAX) begin
                dir_d = 1'b0;
            end else if (duty_d == 4'd0) begin
                dir_d = 1'b1;
            end else begin
                dir_d = w_ramp_up;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            dir_q   <= 1'b1;
        end else begin
            presc_q <= presc_d;
            dir_q   <= dir_d;
        end
    end

    assign ramp_dir = dir_q;
`else
    logic unused_ramp_en;
    assign unused_ramp_en = ramp_en;
    assign w_ramp_step    = 1'b0;
    assign w_ramp_up      = 1'b1;
    assign ramp_dir       = 1'b1;
`endif

    assign duty     = duty_q;
    assign duty_upd = upd_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_duty_sequencer.sv
// Scoreboard bench for pwm_duty_sequencer: stimulus queues expected duty_upd events,
// a negedge monitor pops and checks value and arrival cycle.
`default_nettype none
`timescale 1ns/1ps

module tb_pwm_duty_sequencer;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst, inc_btn, dec_btn, ramp_en;
    logic [3:0] duty;
    logic       duty_upd, ramp_dir;

    pwm_duty_sequencer #(
        .DEB_CYCLES(DEB), .DUTY_MAX(10), .DUTY_RST(5), .RAMP_DIV(16)
    ) dut (
        .clk(clk), .rst(rst), .inc_btn(inc_btn), .dec_btn(dec_btn),
        .ramp_en(ramp_en), .duty(duty), .duty_upd(duty_upd), .ramp_dir(ramp_dir)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int val;
        int at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;
    int   model       = 5;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int val, input int at);
        exp_t e;
        e.val = val;
        e.at  = at;
        sb.push_back(e);
    endtask

    // Monitor: every duty_upd pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (duty_upd) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_upd: got duty_upd=1 duty=%0d expected no pulse (cycle %0d)", duty, cyc);
            end else begin
                mon_e = sb.pop_front();
                if ((int'(duty) != mon_e.val) || (cyc != mon_e.at)) begin
                    miscompares++;
                    $display("FAIL upd_event: got duty=%0d at cycle %0d expected duty=%0d at cycle %0d",
                             duty, cyc, mon_e.val, mon_e.at);
                end
            end
        end
    end

    // One clean press; the step lands 2+DEB edges after the first sampling edge.
    task automatic press(input bit up, input bit dn, input int hold);
        @(negedge clk);
        inc_btn = up;
        dec_btn = dn;
        if (up && !dn && model < 10) begin
            model++;
            push(model, cyc + 2 + DEB + 1);
        end else if (dn && !up && model > 0) begin
            model--;
            push(model, cyc + 2 + DEB + 1);
        end
        repeat (hold) @(negedge clk);
        inc_btn = 1'b0;
        dec_btn = 1'b0;
        repeat (2 * DEB + 6) @(negedge clk);
    endtask

    initial begin
        rst     = 1'b1;
        inc_btn = 1'b0;
        dec_btn = 1'b0;
        ramp_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_duty", int'(duty), 5);
        check("reset_upd", int'(duty_upd), 0);
        check("reset_dir", int'(ramp_dir), 1);

        press(1'b1, 1'b0, 20);                    // 5 -> 6
        check("inc_once", int'(duty), 6);
        press(1'b0, 1'b1, 20);                    // 6 -> 5
        for (int i = 0; i < 5; i++) press(1'b1, 1'b0, 20);
        press(1'b1, 1'b0, 20);                    // saturated at top
        check("sat_max", int'(duty), 10);
        for (int i = 0; i < 10; i++) press(1'b0, 1'b1, 20);
        press(1'b0, 1'b1, 20);                    // saturated at bottom
        check("sat_min", int'(duty), 0);

        // Bounce 1-0-1-0 then stable: one step timed from the stable edge.
        @(negedge clk) inc_btn = 1'b1;
        @(negedge clk) inc_btn = 1'b0;
        @(negedge clk) inc_btn = 1'b1;
        @(negedge clk) inc_btn = 1'b0;
        @(negedge clk) inc_btn = 1'b1;
        model++;
        push(model, cyc + 2 + DEB + 1);
        repeat (20) @(negedge clk);
        inc_btn = 1'b0;
        repeat (2 * DEB + 6) @(negedge clk);
        check("bounce_once", int'(duty), 1);

        // Both buttons together: no step, then FSM must accept a fresh press.
        @(negedge clk);
        inc_btn = 1'b1;
        dec_btn = 1'b1;
        repeat (10) @(negedge clk);
        inc_btn = 1'b0;
        dec_btn = 1'b0;
        repeat (2 * DEB + 6) @(negedge clk);
        check("both_nochange", int'(duty), 1);
        press(1'b1, 1'b0, 20);                    // 1 -> 2
        check("after_both", int'(duty), 2);

        // Reset at PRESS count 3 of 4, button kept high through and after reset.
        @(negedge clk) inc_btn = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        model = 5;
        check("midpress_rst_duty", int'(duty), 5);
        check("midpress_rst_upd", int'(duty_upd), 0);
        model = 6;
        push(model, cyc + 2 + DEB + 1);
        repeat (20) @(negedge clk);
        inc_btn = 1'b0;
        repeat (2 * DEB + 6) @(negedge clk);
        check("repress_after_rst", int'(duty), 6);

`ifdef PWM_RAMP_EN
        @(negedge clk);
        ramp_en = 1'b1;
        begin
            int seq[6] = '{7, 8, 9, 10, 9, 8};
            for (int i = 0; i < 6; i++) push(seq[i], cyc + 16 * (i + 1));
        end
        repeat (6 * 16) @(negedge clk);
        ramp_en = 1'b0;
        repeat (40) @(negedge clk);
        check("ramp_final_duty", int'(duty), 8);
        check("ramp_dir_down", int'(ramp_dir), 0);
`else
        @(negedge clk);
        ramp_en = 1'b1;
        repeat (60) @(negedge clk);
        ramp_en = 1'b0;
        check("noramp_duty", int'(duty), 6);
        check("noramp_dir", int'(ramp_dir), 1);
`endif

        repeat (20) @(negedge clk);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_upd: got no pulse expected duty=%0d at cycle %0d", e.val, e.at);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
